// File: rtl/ex_div_if.sv
// Handshake and operand bundle between the EX stage and the iterative divide sequencer.
// The pipeline side drives the master modport; the sequencer implements the slave.
interface ex_div_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              flush;
  logic [1:0]        div_op;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              stall_req;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start, flush, div_op, dividend, divisor,
    input  stall_req, busy, done, result
  );

  modport slave (
    input  start, flush, div_op, dividend, divisor,
    output stall_req, busy, done, result
  );
endinterface

// File: rtl/ex_div_ctrl.sv
// Radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU.
// It stalls EX while iterating and presents the result for the single FIN cycle.
module ex_div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic    clk,
  input  logic    reset,
  ex_div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] result_q;
  logic              quo_neg_q;
  logic              rem_neg_q;

  logic              accept;
  logic              signed_op;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic              div_zero, ovf, special;
  logic [DATA_W:0]   shifted;
  logic signed [DATA_W+1:0] trial;
  logic              trial_ok;
  logic [DATA_W-1:0] rem_step, quo_step;
  logic [DATA_W-1:0] fin_val;
  logic              stall_c, done_c;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                   input logic neg);
    return neg ? -mag : mag;
  endfunction

  // Operand decode for the accept cycle
  always_comb begin
    signed_op = ~bus.div_op[0];
    a_neg     = signed_op & bus.dividend[DATA_W-1];
    b_neg     = signed_op & bus.divisor[DATA_W-1];
    a_mag     = signed_op ? abs_val($signed(bus.dividend)) : bus.dividend;
    b_mag     = signed_op ? abs_val($signed(bus.divisor))  : bus.divisor;
    div_zero  = (bus.divisor == '0);
    ovf       = signed_op && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
    special   = div_zero | ovf;
  end

  // One restoring step; bit DATA_W of a non-negative trial is always 0,
  // so folding it into the sign test changes nothing but keeps every bit live.
  always_comb begin
    shifted  = {rem_q, quo_q[DATA_W-1]};
    trial    = $signed({1'b0, shifted}) - $signed({2'b00, dvs_q});
    trial_ok = ~(trial[DATA_W+1] | trial[DATA_W]);
    rem_step = trial_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_step = {quo_q[DATA_W-2:0], trial_ok};
  end

  always_comb begin
    fin_val = op_q[1] ? apply_sign(rem_q, rem_neg_q) : apply_sign(quo_q, quo_neg_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    done_c  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          stall_c = 1'b1;
          state_d = special ? FIN : CALC;
        end
      end
      CALC: begin
        stall_c = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush kills whatever is in EX, including a divide being accepted this cycle
    if (bus.flush) begin
      state_d = IDLE;
      stall_c = 1'b0;
      done_c  = 1'b0;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      op_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.div_op;
        cnt_q <= '0;
        dvs_q <= b_mag;
        if (special) begin
          // Preloaded results are final, so sign restoration is disabled
          quo_q     <= div_zero ? '1 : MIN_NEG;
          rem_q     <= div_zero ? bus.dividend : '0;
          quo_neg_q <= 1'b0;
          rem_neg_q <= 1'b0;
        end else begin
          quo_q     <= a_mag;
          rem_q     <= '0;
          quo_neg_q <= a_neg ^ b_neg;
          rem_neg_q <= a_neg;
        end
      end else if ((state_q == CALC) && !bus.flush) begin
        quo_q <= quo_step;
        rem_q <= rem_step;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (done_c) begin
        result_q <= fin_val;
      end
    end
  end

  always_comb begin
    bus.stall_req = stall_c;
    bus.busy      = (state_q != IDLE);
    bus.done      = done_c;
    bus.result    = done_c ? fin_val : result_q;
  end

endmodule
